apb_stream_master: RTL and testbench

APB_STREAM_MASTER -- requirements
Module: apb_stream_master

---
 rtl/apb_stream_master.sv | 170 +++++++++++++++++
 tb/tb_apb_stream_master.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_stream_master.sv
// apb_stream_master: bridges a valid/ready request stream onto an APB master
// port and returns each APB completion (or timeout abort) as a response
// stream. Requests are buffered in a small FIFO; one transfer is in flight
// at a time and responses come back strictly in request order.
module apb_stream_master #(
    parameter type         apb_req_t      = logic [63:0],
    parameter type         apb_resp_t     = logic [31:0],
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned FIFO_DEPTH     = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_req_valid,
    output logic                          o_req_ready,
    input  logic [$bits(apb_req_t)-1:0]   i_req,
    output logic [$bits(apb_req_t)-1:0]   o_apb_m_req,
    output logic                          o_apb_m_psel,
    output logic                          o_apb_m_penable,
    input  logic                          i_apb_m_pready,
    input  logic [$bits(apb_resp_t)-1:0]  i_apb_m_resp,
    output logic                          o_rsp_valid,
    input  logic                          i_rsp_ready,
    output logic [$bits(apb_resp_t)-1:0]  o_rsp,
    output logic                          o_rsp_timeout
);

    localparam int unsigned REQ_W = $bits(apb_req_t);
    localparam int unsigned RSP_W = $bits(apb_resp_t);
    localparam int unsigned PW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = PW + 1;

    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
    localparam logic [15:0]   TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [REQ_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             fifo_empty, fifo_full;
    logic             push, pop;

    logic [REQ_W-1:0] hold_q;
    logic [RSP_W-1:0] rsp_q;
    logic             timeout_q;
    logic [15:0]      acc_cnt_q;
    logic             timeout_hit;

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == FIFO_FULL);
    // Ready comes from the registered count only, so a full FIFO can never
    // see a push and a pop in the same cycle.
    assign o_req_ready = !fifo_full;
    assign push        = i_req_valid && o_req_ready;

    assign timeout_hit = (state_q == ACCESS) && !i_apb_m_pready && (acc_cnt_q == TO_LAST);

    assign o_apb_m_req   = hold_q;
    assign o_rsp         = rsp_q;
    assign o_rsp_timeout = timeout_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state always uses non-blocking assignment so every
        // flop samples its pre-edge inputs regardless of block ordering.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state, FIFO pop and APB/response strobes decoded from the state.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        state_d         = state_q;
        pop             = 1'b0;
        o_apb_m_psel    = 1'b0;
        o_apb_m_penable = 1'b0;
        o_rsp_valid     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                o_apb_m_psel = 1'b1;
                state_d      = ACCESS;
            end
            ACCESS: begin
                o_apb_m_psel    = 1'b1;
                o_apb_m_penable = 1'b1;
                if (i_apb_m_pready || timeout_hit) state_d = RESP;
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage: written on push only.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; the count and pointers define
        // which entries are valid, so stale contents are never observed.
        if (push) mem[wr_ptr_q] <= i_req;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Holding register: the request presented on the APB bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   hold_q <= '0;
        else if (pop) hold_q <= mem[rd_ptr_q];
    end

    // ACCESS-cycle counter: zero outside ACCESS, counts wait states inside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  acc_cnt_q <= '0;
        else if (state_q != ACCESS)  acc_cnt_q <= '0;
        else if (!i_apb_m_pready)    acc_cnt_q <= acc_cnt_q + 16'd1;
    end

    // Response capture: slave data on completion, zero with flag on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q     <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == ACCESS) begin
            if (i_apb_m_pready) begin
                rsp_q     <= i_apb_m_resp;
                timeout_q <= 1'b0;
            end else if (timeout_hit) begin
                rsp_q     <= '0;
                timeout_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_stream_master.sv
// Testbench for apb_stream_master: directed timing cases, FIFO back-pressure,
// mid-transfer reset and a randomised scoreboard run against an APB slave model.
module tb_apb_stream_master;

    localparam int TO       = 8;
    localparam int N_STRESS = 6000;

    typedef struct {
        logic [63:0] req;
        int          waitc;
    } slv_t;

    typedef struct {
        logic [31:0] data;
        logic        tmo;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [63:0] i_req;
    logic [63:0] o_apb_m_req;
    logic        o_apb_m_psel;
    logic        o_apb_m_penable;
    logic        i_apb_m_pready;
    logic [31:0] i_apb_m_resp;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp;
    logic        o_rsp_timeout;

    int checks   = 0;
    int failures = 0;

    slv_t slv_q[$];
    exp_t exp_q[$];
    slv_t cur;
    int   acc       = 0;
    bit   active    = 0;
    int   next_wait = 0;
    int   rsp_seen  = 0;

    apb_stream_master #(
        .TIMEOUT_CYCLES(TO),
        .FIFO_DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req          (i_req),
        .o_apb_m_req    (o_apb_m_req),
        .o_apb_m_psel   (o_apb_m_psel),
        .o_apb_m_penable(o_apb_m_penable),
        .i_apb_m_pready (i_apb_m_pready),
        .i_apb_m_resp   (i_apb_m_resp),
        .o_rsp_valid    (o_rsp_valid),
        .i_rsp_ready    (i_rsp_ready),
        .o_rsp          (o_rsp),
        .o_rsp_timeout  (o_rsp_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] slave_data(input logic [63:0] r);
        return r[31:0] ^ r[63:32] ^ 32'h5A5A_A5A5;
    endfunction

    function automatic int exp_len(input int w);
        return (w >= TO) ? TO : w + 1;
    endfunction

    // One clock of the scoreboard environment, entered and left at a negedge.
    task automatic tick(input bit rsp_rdy, output bit accepted);
        exp_t e;
        slv_t s;
        accepted = 1'b0;
        if (o_apb_m_penable) check("penable_needs_psel", o_apb_m_psel, 1'b1);
        if (o_rsp_valid)     check("psel_low_in_resp", o_apb_m_psel, 1'b0);

        if (o_apb_m_psel && !o_apb_m_penable) begin
            if (slv_q.size() == 0) begin
                check("setup_without_request", o_apb_m_psel, 1'b0);
            end else begin
                cur    = slv_q.pop_front();
                acc    = 0;
                active = 1'b1;
                check("setup_req", o_apb_m_req, cur.req);
            end
            i_apb_m_pready = 1'($urandom_range(0, 1));
            i_apb_m_resp   = $urandom;
        end else if (o_apb_m_psel && o_apb_m_penable) begin
            check("access_req_stable", o_apb_m_req, cur.req);
            i_apb_m_pready = (acc == cur.waitc);
            i_apb_m_resp   = slave_data(o_apb_m_req);
            acc++;
        end else begin
            i_apb_m_pready = 1'($urandom_range(0, 1));
            i_apb_m_resp   = $urandom;
        end

        i_rsp_ready = rsp_rdy;
        if (o_rsp_valid && active) begin
            check("access_len", acc, exp_len(cur.waitc));
            active = 1'b0;
        end
        if (o_rsp_valid && rsp_rdy) begin
            if (exp_q.size() == 0) begin
                check("rsp_without_request", o_rsp_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", o_rsp, e.data);
                check("rsp_timeout", o_rsp_timeout, e.tmo);
                rsp_seen++;
            end
        end

        if (i_req_valid && o_req_ready) begin
            s.req   = i_req;
            s.waitc = next_wait;
            slv_q.push_back(s);
            e.tmo  = (next_wait >= TO);
            e.data = e.tmo ? 32'h0 : slave_data(i_req);
            exp_q.push_back(e);
            accepted = 1'b1;
        end
        @(negedge clk);
    endtask

    // Single directed transfer with a hand-driven slave; records the bus trace.
    task automatic run_one(input logic [63:0] req, input int waitc, input logic [31:0] rdata,
                           output int psel_n, output int pen_n, output int valid_idx,
                           output bit stable, output logic [31:0] rsp, output logic tmo);
        int a;
        bit done;
        psel_n = 0; pen_n = 0; valid_idx = -1; stable = 1'b1;
        rsp = '0; tmo = 1'b0; a = 0; done = 1'b0;
        i_req_valid    = 1'b1;
        i_req          = req;
        i_rsp_ready    = 1'b1;
        i_apb_m_resp   = rdata;
        i_apb_m_pready = 1'b0;
        @(negedge clk);
        i_req_valid = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            if (o_apb_m_psel) begin
                psel_n++;
                if (o_apb_m_req !== req) stable = 1'b0;
            end
            if (o_apb_m_penable) begin
                pen_n++;
                i_apb_m_pready = (a == waitc);
                a++;
            end else begin
                i_apb_m_pready = 1'b0;
            end
            if (o_rsp_valid) begin
                valid_idx = k;
                rsp       = o_rsp;
                tmo       = o_rsp_timeout;
                done      = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int psel_n, pen_n, vidx, early, viol, issued, seen0;
        bit stable, accf, got, pending;
        logic [31:0] rsp;
        logic tmo;
        logic [63:0] r;
        logic [63:0] reqs [4];

        rst_n          = 1'b0;
        i_req_valid    = 1'b0;
        i_req          = '0;
        i_apb_m_pready = 1'b0;
        i_apb_m_resp   = '0;
        i_rsp_ready    = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_psel", o_apb_m_psel, 1'b0);
        check("rst_penable", o_apb_m_penable, 1'b0);
        check("rst_rsp_valid", o_rsp_valid, 1'b0);
        check("rst_rsp", o_rsp, 32'h0);
        check("rst_timeout", o_rsp_timeout, 1'b0);
        check("rst_apb_req", o_apb_m_req, 64'h0);
        rst_n = 1'b1;
        #1 check("ready_after_reset", o_req_ready, 1'b1);
        @(negedge clk);

        // Single write, zero wait states: psel 2 cycles, penable 1, rsp at N+4.
        run_one(64'h0000_1000_DEAD_BEEF, 0, 32'h0BAD_F00D, psel_n, pen_n, vidx, stable, rsp, tmo);
        check("wr_psel_cycles", psel_n, 2);
        check("wr_penable_cycles", pen_n, 1);
        check("wr_rsp_latency", vidx, 3);
        check("wr_req_stable", stable, 1'b1);
        check("wr_rsp_data", rsp, 32'h0BAD_F00D);
        check("wr_timeout", tmo, 1'b0);
        check("wr_rsp_valid_drops", o_rsp_valid, 1'b0);

        // Read with five wait states.
        run_one(64'h0000_0000_0000_2000, 5, 32'h1234_5678, psel_n, pen_n, vidx, stable, rsp, tmo);
        check("rd_access_cycles", pen_n, 6);
        check("rd_psel_cycles", psel_n, 7);
        check("rd_rsp_latency", vidx, 8);
        check("rd_req_stable", stable, 1'b1);
        check("rd_rsp_data", rsp, 32'h1234_5678);
        check("rd_timeout", tmo, 1'b0);

        // Slave never ready: abort after exactly TO ACCESS cycles.
        run_one(64'h0000_0003_0000_3000, 1000, 32'hFFFF_FFFF, psel_n, pen_n, vidx, stable, rsp, tmo);
        check("to_access_cycles", pen_n, TO);
        check("to_psel_cycles", psel_n, TO + 1);
        check("to_rsp_latency", vidx, TO + 2);
        check("to_rsp_data", rsp, 32'h0);
        check("to_timeout", tmo, 1'b1);

        // Ready on the last permitted ACCESS cycle: completion wins.
        run_one(64'h0000_0004_0000_4000, TO - 1, 32'h7777_1111, psel_n, pen_n, vidx, stable, rsp, tmo);
        check("edge_access_cycles", pen_n, TO);
        check("edge_rsp_data", rsp, 32'h7777_1111);
        check("edge_timeout", tmo, 1'b0);

        // Back-pressure: three back-to-back pushes fill holding reg + FIFO.
        reqs[0] = 64'h1111_0000_0000_0001;
        reqs[1] = 64'h2222_0000_0000_0002;
        reqs[2] = 64'h3333_0000_0000_0003;
        reqs[3] = 64'h4444_0000_0000_0004;
        next_wait   = 0;
        i_req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_req = reqs[k];
            tick(1'b0, accf);
            check("b2b_accept", accf, 1'b1);
        end
        i_req = reqs[3];
        check("full_ready_low", o_req_ready, 1'b0);
        early = 0;
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, accf);
            if (accf) early++;
        end
        check("no_accept_while_stalled", early, 0);
        seen0 = rsp_seen;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick(1'b1, accf);
            if (accf) begin
                got = 1'b1;
                check("accept_after_handshake", rsp_seen > seen0, 1'b1);
            end
        end
        check("fourth_accepted", got, 1'b1);
        i_req_valid = 1'b0;
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) tick(1'b1, accf);
        check("bp_drained", exp_q.size(), 0);

        // Reset during ACCESS with two requests queued.
        next_wait   = TO + 5;
        i_req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_req = reqs[k] ^ 64'hF0;
            tick(1'b0, accf);
        end
        i_req_valid = 1'b0;
        for (int k = 0; k < 10 && !o_apb_m_penable; k++) tick(1'b0, accf);
        check("reach_access", o_apb_m_penable, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_psel", o_apb_m_psel, 1'b0);
        check("mid_rst_penable", o_apb_m_penable, 1'b0);
        check("mid_rst_rsp_valid", o_rsp_valid, 1'b0);
        check("mid_rst_apb_req", o_apb_m_req, 64'h0);
        check("mid_rst_rsp", o_rsp, 32'h0);
        check("mid_rst_timeout", o_rsp_timeout, 1'b0);
        slv_q.delete();
        exp_q.delete();
        active = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("mid_rst_ready", o_req_ready, 1'b1);
        @(negedge clk);
        viol = 0;
        for (int k = 0; k < 20; k++) begin
            if (o_rsp_valid || o_apb_m_psel) viol++;
            tick(1'b1, accf);
        end
        check("silent_after_reset", viol, 0);

        // Randomised scoreboard run.
        issued  = 0;
        pending = 1'b0;
        r       = '0;
        for (int cyc = 0; cyc < 80000 && (issued < N_STRESS || exp_q.size() != 0); cyc++) begin
            if (!pending && issued < N_STRESS) begin
                int sel;
                r   = {$urandom, $urandom};
                sel = $urandom_range(0, 19);
                if (sel < 10)       next_wait = 0;
                else if (sel < 18)  next_wait = 1 + (sel % 3);
                else if (sel == 18) next_wait = TO - 1;
                else                next_wait = ($urandom_range(0, 1) != 0) ? TO : TO + 3;
                pending = 1'b1;
            end
            i_req       = r;
            i_req_valid = pending && ($urandom_range(0, 9) < 7);
            tick($urandom_range(0, 3) != 0, accf);
            if (accf) begin
                pending = 1'b0;
                issued++;
            end
        end
        i_req_valid = 1'b0;
        check("stress_issued", issued, N_STRESS);
        check("stress_sb_empty", exp_q.size(), 0);
        check("stress_slave_q_empty", slv_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
